debounce_pulse_array: RTL and testbench
=======================================

DEBOUNCE_PULSE_ARRAY -- requirements
Module: debounce_pulse_array

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels (>=1).
REQ-002 Parameter DB_CYCLES, default 4: consecutive mismatching samples required to accept a level change (>=1).
REQ-003 Parameter LONG_CYCLES, default 16: debounced-high cycles that qualify as a long press (>=1).
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 button  input  N_CH: raw asynchronous button levels, one bit per channel.
REQ-007 mode  input  2: edge-pulse select, global to all channels: 00 rising, 01 falling, 10 both, 11 pulses disabled.
REQ-008 level  output  N_CH: debounced button level per channel.
REQ-009 pulse  output  N_CH: single-cycle edge pulse per channel, per mode.
REQ-010 long_press  output  N_CH: single-cycle pulse per channel when a long press qualifies.
REQ-011 any_pulse  output  1: OR of all pulse bits, registered together with pulse.

Function
REQ-012 Each channel SHALL pass button through a 2-flop synchronizer; only the second flop output (sync) feeds channel logic.
REQ-013 Each channel SHALL keep a debounce counter, ceil(log2(DB_CYCLES+1)) bits: increment on each edge where sync != level; clear on any edge where sync == level.
REQ-014 On the edge where the counter would reach DB_CYCLES, level SHALL toggle and the counter SHALL clear.
REQ-015 Latency from a stable raw change (set up before edge 1) to level update SHALL be exactly DB_CYCLES+2 edges (6 at defaults).
REQ-016 A raw excursion shorter than DB_CYCLES synchronized samples SHALL cause no change to level, pulse or long_press.
REQ-017 pulse[i] SHALL assert for exactly one cycle, registered, on the same edge level[i] toggles, when the toggle direction matches mode (10: either direction; 11: never).
REQ-018 mode SHALL be sampled on the toggle edge; a mode change affects only subsequent toggles and never creates or truncates a pulse.
REQ-019 Each channel SHALL keep a hold counter, ceil(log2(LONG_CYCLES+1)) bits: clear while level==0, increment while level==1, saturate at LONG_CYCLES.
REQ-020 long_press[i] SHALL assert for one cycle on the edge the hold counter reaches LONG_CYCLES (LONG_CYCLES edges after level rises); at most once per press; re-arms only after level returns to 0.
REQ-021 A release before LONG_CYCLES SHALL clear the hold counter with no long_press.
REQ-022 long_press SHALL be independent of mode, including 11.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 any_pulse SHALL equal the OR of the registered pulse bits in the same cycle (long_press excluded).

Reset
REQ-025 While rst_n==0: synchronizers, counters, level, pulse, long_press and any_pulse SHALL all be 0, taking effect immediately, without waiting for a clock edge.
REQ-026 After rst_n deasserts, a button held high SHALL be treated as a new press (level rises DB_CYCLES+2 edges later, with a rising pulse in modes 00/10).
REQ-027 Reset asserted mid-debounce or mid-hold SHALL discard partial counts; no pulse or long_press SHALL be emitted for the interrupted event.

Verification (clk 10 ns, defaults)
REQ-028 Reset: button=4'b0001 held, rst_n low 3 cycles then high, mode=00 -> all outputs 0 during reset; level[0]=1 and pulse[0]=1 for one cycle exactly 6 edges after release.
REQ-029 Glitch: button[1] high for 3 cycles then low -> level[1], pulse[1], long_press[1] stay 0 throughout.
REQ-030 Modes: button[2] high 10 cycles then low; with mode=00 -> one pulse on the rise only; with mode=01 -> one pulse on the fall only; with mode=10 -> two pulses; with mode=11 -> none; level[2] follows the press in all four modes.
REQ-031 Long press: button[0] high 30 cycles -> long_press[0] one cycle, 16 edges after level[0] rises, never repeated; a second 10-cycle press -> no long_press.
REQ-032 Simultaneous: button[0] and button[3] rise on the same cycle with mode=00 -> pulse=4'b1001 for one cycle, any_pulse=1 for that same cycle only.
REQ-033 Reset mid-operation: pull rst_n low when button[1]'s debounce count is 3 -> outputs 0 immediately; after release with button[1] still high -> a full 6-edge debounce restarts.

Source files
------------

// File: rtl/debounce_pulse_array.sv
// Per-channel button debouncer with edge pulses and long-press detection.
// One lane instance per channel; any_pulse is registered alongside the lane pulses.

module debounce_pulse_lane #(
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    input  logic [1:0] mode,
    output logic       level,
    output logic       pulse,
    output logic       pulse_set,
    output logic       long_press
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    logic          s1, sync;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold;
    logic          toggle;

    // Toggle on the edge where the mismatch count would reach DB_CYCLES.
    assign toggle = (sync != level) && (db_cnt == DW'(DB_CYCLES - 1));

    always_comb begin
        pulse_set = 1'b0;
        case (mode)
            2'b00:   pulse_set = toggle && !level;
            2'b01:   pulse_set = toggle && level;
            2'b10:   pulse_set = toggle;
            default: pulse_set = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            sync       <= 1'b0;
            db_cnt     <= '0;
            level      <= 1'b0;
            pulse      <= 1'b0;
            hold       <= '0;
            long_press <= 1'b0;
        end else begin
            s1    <= button;
            sync  <= s1;
            pulse <= pulse_set;
            if (sync == level) begin
                db_cnt <= '0;
            end else if (toggle) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            // Hold counter saturates, so long_press fires once per press.
            if (!level)
                hold <= '0;
            else if (hold != HW'(LONG_CYCLES))
                hold <= hold + HW'(1);
            long_press <= level && (hold == HW'(LONG_CYCLES - 1));
        end
    end
endmodule

module debounce_pulse_array #(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 4,
    parameter int LONG_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] button,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] pulse,
    output logic [N_CH-1:0] long_press,
    output logic            any_pulse
);
    logic [N_CH-1:0] pulse_set;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        debounce_pulse_lane #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .button    (button[i]),
            .mode      (mode),
            .level     (level[i]),
            .pulse     (pulse[i]),
            .pulse_set (pulse_set[i]),
            .long_press(long_press[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_pulse <= 1'b0;
        else        any_pulse <= |pulse_set;
    end
endmodule

// File: tb/tb_debounce_pulse_array.sv
// Randomized + directed bench for debounce_pulse_array against a window-based reference model.

module tb_debounce_pulse_array;
    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LG = 16;

    logic         clk, rst_n;
    logic [N-1:0] button;
    logic [1:0]   mode;
    logic [N-1:0] level, pulse, long_press;
    logic         any_pulse;

    debounce_pulse_array #(.N_CH(N), .DB_CYCLES(DB), .LONG_CYCLES(LG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button    (button),
        .mode      (mode),
        .level     (level),
        .pulse     (pulse),
        .long_press(long_press),
        .any_pulse (any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: level flips once the last DB synchronized samples all
    // disagree with it; long press fires exactly LG edges after the rise.
    logic [N-1:0] pipe[$];
    logic [N-1:0] sq[$];
    logic [N-1:0] m_level, m_pulse, m_long;
    logic         m_any;
    int           rise_edge[N];
    int           n_edge = 0;

    task automatic model_reset();
        pipe = {};
        pipe.push_back('0);
        pipe.push_back('0);
        sq = {};
        m_level = '0; m_pulse = '0; m_long = '0; m_any = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic [1:0] m);
        logic [N-1:0] samp, e, nl;
        n_edge++;
        samp = pipe.pop_front();
        pipe.push_back(b);
        sq.push_back(samp);
        if (sq.size() > DB) void'(sq.pop_front());
        nl = m_level;
        for (int ch = 0; ch < N; ch++) begin
            bit tog, rise;
            tog = (sq.size() == DB);
            for (int k = 0; k < sq.size(); k++) begin
                e = sq[k];
                if (e[ch] == m_level[ch]) tog = 1'b0;
            end
            rise = !m_level[ch];
            m_pulse[ch] = tog && (m == 2'b10 || (m == 2'b00 && rise) || (m == 2'b01 && !rise));
            m_long[ch]  = m_level[ch] && (n_edge == rise_edge[ch] + LG);
            if (tog) begin
                nl[ch] = ~m_level[ch];
                if (rise) rise_edge[ch] = n_edge;
            end
        end
        m_level = nl;
        m_any   = |m_pulse;
    endtask

    task automatic step();
        logic [N-1:0] b;
        logic [1:0]   m;
        logic         r;
        b = button; m = mode; r = rst_n;
        @(posedge clk);
        if (r) model_edge(b, m);
        #1;
        chk("level", level, m_level);
        chk("pulse", pulse, m_pulse);
        chk("long", long_press, m_long);
        chk("any", any_pulse, m_any);
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async", {level, pulse, long_press, any_pulse}, '0);
        repeat (cyc) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, cnt2, rs, ls;
        bit flag, found;
        logic [N-1:0] v;
        rst_n = 1'b1; button = 4'b0001; mode = 2'b00;
        model_reset();
        for (int i = 0; i < N; i++) rise_edge[i] = -1000;
        #2;

        // Reset with button[0] held: fresh press 6 edges after release
        do_reset(3);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) chk("rst_lat_lo", level[0], 1'b0);
        end
        chk("rst_lat_level", level[0], 1'b1);
        chk("rst_lat_pulse", pulse[0], 1'b1);
        step();
        chk("rst_pulse_1cyc", pulse[0], 1'b0);
        button = '0;
        repeat (25) step();

        // Glitch on channel 1
        button[1] = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) button[1] = 1'b0;
            step();
            if (level[1] || pulse[1] || long_press[1]) flag = 1'b1;
        end
        chk("glitch", flag, 1'b0);

        // Mode sweep on channel 2
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            button[2] = 1'b1;
            cnt = 0; cnt2 = 0;
            for (int i = 0; i < 22; i++) begin
                if (i == 10) button[2] = 1'b0;
                step();
                if (pulse[2]) cnt++;
                if (level[2]) cnt2++;
            end
            chk("mode_pulses", cnt, (m == 2) ? 2 : (m == 3) ? 0 : 1);
            chk("mode_level", cnt2, 10);
        end
        mode = 2'b00;

        // Long press then short press on channel 0
        button[0] = 1'b1;
        cnt = 0; rs = -1; ls = -1;
        for (int i = 0; i < 40; i++) begin
            if (i == 30) button[0] = 1'b0;
            step();
            if (level[0] && rs < 0) rs = i;
            if (long_press[0]) begin cnt++; ls = i; end
        end
        chk("long_cnt", cnt, 1);
        chk("long_dist", ls - rs, LG);
        button[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) button[0] = 1'b0;
            step();
            if (long_press[0]) cnt++;
        end
        chk("short_nolong", cnt, 0);

        // Simultaneous rise on channels 0 and 3
        button = 4'b1001;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (pulse != '0) found = 1'b1;
        end
        chk("sim_found", found, 1'b1);
        chk("sim_pulse", pulse, 4'b1001);
        chk("sim_any", any_pulse, 1'b1);
        step();
        chk("sim_any_1cyc", any_pulse, 1'b0);
        button = '0;
        repeat (25) step();

        // Reset while channel 1 is mid-debounce (count 3 after edge 5)
        button = 4'b0010;
        repeat (5) step();
        do_reset(2);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i < 6) chk("rmid_lo", level[1], 1'b0);
        end
        chk("rmid_level", level[1], 1'b1);
        chk("rmid_pulse", pulse[1], 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) begin
                v = button;
                v[$urandom_range(N-1)] ^= 1'b1;
                button = v;
            end
            if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(299) == 0) do_reset(2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
